// File: rtl/mem_pkg.sv
// mem_pkg: size codes, FSM state and fault causes shared by the memory access unit.
package mem_pkg;
  localparam logic [3:0] SZ_WORD  = 4'b1111;
  localparam logic [3:0] SZ_HALF  = 4'b0011;
  localparam logic [3:0] SZ_BYTE  = 4'b0001;
  localparam logic [3:0] SZ_BYTE0 = 4'b0000;
  typedef enum logic [1:0] {IDLE, RD_REQ, WR_REQ, DONE} mau_state_t;
  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_ILLEGAL  = 2'd1;
  localparam logic [1:0] FC_MISALIGN = 2'd2;
  localparam logic [1:0] FC_TIMEOUT  = 2'd3;
  function automatic logic size_legal(input logic [3:0] be);
    return be == SZ_WORD || be == SZ_HALF || be == SZ_BYTE || be == SZ_BYTE0;
  endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: little-endian lane extract/extend for loads and lane merge for sub-word stores.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [3:0]  size,
  input  logic        sgn,
  input  logic [31:0] data,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);
  logic [31:0] bsh, hsh, bmask, hmask;
  always_comb begin
    bsh     = word >> {off, 3'b000};
    hsh     = word >> {off[1], 4'b0000};
    bmask   = 32'h0000_00ff << {off, 3'b000};
    hmask   = 32'h0000_ffff << {off[1], 4'b0000};
    ld_data = size == SZ_WORD ? word :
              size == SZ_HALF ? {{16{sgn & hsh[15]}}, hsh[15:0]} :
                                {{24{sgn & bsh[7]}}, bsh[7:0]};
    st_word = size == SZ_WORD ? data :
              size == SZ_HALF ? (word & ~hmask) | ({16'b0, data[15:0]} << {off[1], 4'b0000}) :
                                (word & ~bmask) | ({24'b0, data[7:0]} << {off, 3'b000});
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit driving a req/ack word memory, RMW for sub-word stores.
// Define MAU_MISALIGN_TRAP_EN to fault misaligned halfword/word accesses instead of truncating.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              MemW,
  input  logic              Signed,
  input  logic [3:0]        ByteEnable,
  input  logic [ADDR_W-1:0] Adr,
  input  logic [31:0]       WriteData,
  output logic [31:0]       ReadData,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES - 1);
  mau_state_t        state;
  logic              we_r, sgn_r, mis, legal, expired;
  logic [3:0]        be_r;
  logic [ADDR_W-1:0] adr_r;
  logic [31:0]       wdata_r, ld_data, st_word;
  logic [CW-1:0]     cnt;
  logic [1:0]        cause;
  mem_lane_align u_align (
    .word(mem_rdata), .off(adr_r[1:0]), .size(be_r), .sgn(sgn_r), .data(wdata_r),
    .ld_data(ld_data), .st_word(st_word)
  );
`ifdef MAU_MISALIGN_TRAP_EN
  assign mis = (ByteEnable == SZ_HALF && Adr[0]) || (ByteEnable == SZ_WORD && Adr[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif
  assign legal   = size_legal(ByteEnable);
  assign expired = !mem_ack && cnt == T_LAST;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      we_r     <= 1'b0;
      sgn_r    <= 1'b0;
      be_r     <= '0;
      adr_r    <= '0;
      wdata_r  <= '0;
      ReadData <= '0;
      cnt      <= '0;
      cause    <= FC_NONE;
    end else begin
      case (state)
        IDLE: if (start) begin
          we_r    <= MemW;
          sgn_r   <= Signed;
          be_r    <= ByteEnable;
          adr_r   <= Adr;
          wdata_r <= WriteData;
          cnt     <= '0;
          cause   <= !legal ? FC_ILLEGAL : mis ? FC_MISALIGN : FC_NONE;
          state   <= (!legal || mis) ? DONE : (MemW && ByteEnable == SZ_WORD) ? WR_REQ : RD_REQ;
        end
        RD_REQ: if (mem_ack) begin
          cnt <= '0;
          if (we_r) begin
            wdata_r <= st_word;
            state   <= WR_REQ;
          end else begin
            ReadData <= ld_data;
            state    <= DONE;
          end
        end else if (expired) begin
          cause <= FC_TIMEOUT;
          state <= DONE;
        end else cnt <= cnt + 1'b1;
        WR_REQ: if (mem_ack) state <= DONE;
        else if (expired) begin
          cause <= FC_TIMEOUT;
          state <= DONE;
        end else cnt <= cnt + 1'b1;
        default: begin
          cause <= FC_NONE;
          state <= IDLE;
        end
      endcase
    end
  end
  assign busy      = state != IDLE;
  assign done      = state == DONE;
  assign fault     = done && cause != FC_NONE;
  assign mem_req   = state == RD_REQ || state == WR_REQ;
  assign mem_we    = state == WR_REQ;
  assign mem_adr   = {adr_r[ADDR_W-1:2], 2'b00};
  assign mem_wdata = wdata_r;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized commands checked against a byte-array memory model.
module tb_mem_access_unit;
  localparam int TO = 4;
  logic        clk = 0, reset_n = 0, start = 0, MemW = 0, Signed = 0, mem_ack = 0;
  logic [3:0]  ByteEnable = 0;
  logic [31:0] Adr = 0, WriteData = 0, mem_rdata = 0;
  logic [31:0] ReadData, mem_adr, mem_wdata;
  logic        busy, done, fault, mem_req, mem_we;
  logic [31:0] mw [256];
  logic [7:0]  mb [1024];
  logic [31:0] exp_rd = 0;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  mem_access_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .MemW(MemW), .Signed(Signed),
    .ByteEnable(ByteEnable), .Adr(Adr), .WriteData(WriteData), .ReadData(ReadData),
    .busy(busy), .done(done), .fault(fault), .mem_req(mem_req), .mem_we(mem_we),
    .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic set_word(input int idx, input logic [31:0] v);
    mw[idx] = v;
    for (int i = 0; i < 4; i++) mb[idx*4+i] = 8'((v >> (8*i)) & 32'hff);
  endtask
  // d1/d2: request cycles to wait before acking the first/second request phase (>= TO never acks)
  task automatic run_cmd(input logic we, input logic sg, input logic [3:0] be,
                         input logic [31:0] a, input logic [31:0] wd, input int d1, input int d2);
    int nb, base, lat, nreq_e, nreq, nwr, phase, pc, got_lat, idx;
    logic lgl, mis, rmw, exp_fault, got_fault, ack;
    logic [31:0] v, exp_word;
    lgl  = be == 4'hF || be == 4'h3 || be == 4'h1 || be == 4'h0;
    nb   = be == 4'hF ? 4 : be == 4'h3 ? 2 : 1;
    base = int'(a[9:0]) & ~(nb - 1);
    idx  = int'(a[9:2]);
`ifdef MAU_MISALIGN_TRAP_EN
    mis = base != int'(a[9:0]);
`else
    mis = 1'b0;
`endif
    rmw = we && nb < 4;
    if (!lgl || mis) begin lat = 1; nreq_e = 0; exp_fault = 1; end
    else if (d1 >= TO) begin lat = 1 + TO; nreq_e = TO; exp_fault = 1; end
    else if (!rmw) begin lat = 2 + d1; nreq_e = d1 + 1; exp_fault = 0; end
    else if (d2 >= TO) begin lat = 2 + d1 + TO; nreq_e = d1 + 1 + TO; exp_fault = 1; end
    else begin lat = 3 + d1 + d2; nreq_e = d1 + d2 + 2; exp_fault = 0; end
    if (!exp_fault && !we) begin
      v = 0;
      for (int i = 0; i < nb; i++) v |= 32'(mb[base+i]) << (8*i);
      if (sg && nb < 4 && v[8*nb-1]) v |= 32'hffff_ffff << (8*nb);
      exp_rd = v;
    end
    if (!exp_fault && we)
      for (int i = 0; i < nb; i++) mb[base+i] = 8'((wd >> (8*i)) & 32'hff);
    exp_word = {mb[idx*4+3], mb[idx*4+2], mb[idx*4+1], mb[idx*4]};
    @(negedge clk);
    start = 1; MemW = we; Signed = sg; ByteEnable = be; Adr = a; WriteData = wd;
    nreq = 0; nwr = 0; phase = 0; pc = 0; got_lat = -1; got_fault = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (done) begin
        got_lat = k;
        got_fault = fault;
        start = 0;
        mem_ack = 0;
        break;
      end
      if (mem_req) begin
        nreq++;
        chk("mem_adr", mem_adr, {a[31:2], 2'b00});
        chk("mem_we", 32'(mem_we), 32'(phase == 1 || (we && !rmw)));
        ack = pc == (phase == 0 ? d1 : d2);
        mem_ack = ack;
        mem_rdata = ack && !mem_we ? mw[mem_adr[9:2]] : $urandom;
        if (ack && mem_we) begin
          chk("mem_wdata", mem_wdata, exp_word);
          mw[mem_adr[9:2]] = mem_wdata;
          nwr++;
        end
        if (ack) begin phase++; pc = 0; end else pc++;
      end else begin
        mem_ack = 1'($urandom);
        mem_rdata = $urandom;
      end
      start = 1'($urandom); MemW = 1'($urandom); Signed = 1'($urandom);
      ByteEnable = 4'($urandom); Adr = $urandom; WriteData = $urandom;
    end
    start = 0;
    chk("latency", 32'(got_lat), 32'(lat));
    chk("fault", 32'(got_fault), 32'(exp_fault));
    chk("req_cycles", 32'(nreq), 32'(nreq_e));
    chk("writes", 32'(nwr), 32'(!exp_fault && we));
    chk("ReadData", ReadData, exp_rd);
    chk("mem_word", mw[idx], exp_word);
    @(negedge clk);
    chk("idle_after", {30'b0, busy, done}, 32'h0);
  endtask
  initial begin
    logic [3:0] be;
    for (int i = 0; i < 256; i++) set_word(i, $urandom);
    #2;
    chk("rst_outs", {27'b0, busy, done, fault, mem_req, mem_we}, 32'h0);
    chk("rst_rd", ReadData, 32'h0);
    chk("rst_adr", mem_adr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    @(negedge clk) reset_n = 1;
    set_word(64, 32'hDEADBEEF);
    run_cmd(0, 0, 4'hF, 32'h100, 0, 0, 0);
    chk("plan_word", ReadData, 32'hDEADBEEF);
    set_word(64, 32'h12805634);
    run_cmd(0, 1, 4'h1, 32'h102, 0, 0, 0);
    chk("plan_sbyte", ReadData, 32'hFFFFFF80);
    run_cmd(0, 0, 4'h1, 32'h102, 0, 0, 0);
    chk("plan_ubyte", ReadData, 32'h00000080);
    set_word(128, 32'h11223344);
    run_cmd(1, 0, 4'h3, 32'h202, 32'h0000ABCD, 0, 0);
    chk("plan_rmw", mw[128], 32'hABCD3344);
    run_cmd(0, 0, 4'hF, 32'h100, 0, 99, 0);
    run_cmd(1, 1, 4'h1, 32'h203, 32'h55, 1, 99);
    run_cmd(0, 0, 4'hF, 32'h104, 0, 3, 0);
    run_cmd(0, 0, 4'hF, 32'h101, 0, 0, 0);
    run_cmd(0, 1, 4'h3, 32'h103, 0, 1, 0);
    run_cmd(1, 0, 4'h6, 32'h110, 32'h1234, 0, 0);
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 7))
        0, 4: be = 4'hF;
        1, 5: be = 4'h3;
        2, 6: be = 4'h1;
        3:    be = 4'h0;
        default: be = 4'($urandom);
      endcase
      run_cmd(1'($urandom), 1'($urandom), be, $urandom, $urandom,
              $urandom_range(0, 9) == 0 ? 99 : $urandom_range(0, 3),
              $urandom_range(0, 9) == 0 ? 99 : $urandom_range(0, 3));
    end
    @(negedge clk);
    start = 1; MemW = 0; Signed = 0; ByteEnable = 4'hF; Adr = 32'h100;
    @(negedge clk) start = 0;
    @(negedge clk);
    #2 reset_n = 0;
    #1;
    exp_rd = 0;
    chk("midrst_outs", {27'b0, busy, done, fault, mem_req, mem_we}, 32'h0);
    chk("midrst_rd", ReadData, exp_rd);
    @(negedge clk) reset_n = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("midrst_quiet", {30'b0, busy, done}, 32'h0);
    end
    run_cmd(0, 1, 4'h3, 32'h106, 0, 2, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store execution unit on the consuming end of the decoder's memory controls (MemW, ByteEnable). It turns a datapath memory command into word-aligned accesses on a single-port word memory with a req/ack handshake. Sub-word stores are done as read-modify-write (RMW), and sub-word loads are lane-extracted and extended. It sits between the multicycle datapath/controller and data memory.

Parameters:
ADDR_W, 32, byte-address width.
TIMEOUT_CYCLES, 255, maximum cycles mem_req may wait for mem_ack before a fault; minimum 1.

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
start  input  1  command valid; sampled only in IDLE
MemW  input  1  1 = store, 0 = load
Signed  input  1  sign-extend sub-word loads; ignored for words and stores
ByteEnable  input  4  size code: 1111 word, 0011 halfword, 0001/0000 byte, others illegal
Adr  input  ADDR_W  byte address
WriteData  input  32  store data; sub-word data in low bits
ReadData  output  32  extended load result; held until the next load completes
busy  output  1  state != IDLE
done  output  1  one-cycle completion pulse
fault  output  1  valid with done; illegal code, misalignment, or timeout
mem_req  output  1  memory request
mem_we  output  1  memory write
mem_adr  output  ADDR_W  word address, bits [1:0] forced to 00
mem_wdata  output  32  memory write word
mem_rdata  input  32  memory read word
mem_ack  input  1  request accepted/completed this cycle

Behaviour:
- Reset: all outputs 0, FSM in IDLE, timeout counter 0. Reset asserted mid-operation drops mem_req immediately and aborts the command with no done pulse.
- FSM states: IDLE, RD_REQ, WR_REQ, DONE.
- IDLE + start: register MemW, Signed, ByteEnable, Adr, WriteData.
  - Illegal size code -> DONE with fault = 1, no memory access.
  - Word store -> WR_REQ.
  - Any other legal command (any load, or sub-word store) -> RD_REQ.
- start while busy is ignored; the command is not queued.
- Handshake:
  - mem_req = 1 exactly in RD_REQ and WR_REQ.
  - mem_adr, mem_we, mem_wdata stay stable while mem_req = 1.
  - The transfer completes on the cycle mem_req and mem_ack are both high; mem_req deasserts the next cycle.
  - mem_ack outside a request is ignored.
- RD_REQ on ack:
  - Load: capture the lane from mem_rdata into ReadData -> DONE.
  - Sub-word store: merge the store lane into the read word -> WR_REQ.
- WR_REQ on ack -> DONE. mem_we = 1 only in WR_REQ.
- DONE: done = 1 for one cycle; fault is valid in the same cycle, else 0 -> IDLE.
- Byte lanes are little-endian.
  - Byte: lane Adr[1:0].
  - Halfword: lane Adr[1]; Adr[0] is ignored unless MAU_MISALIGN_TRAP_EN is defined.
  - Word: Adr[1:0] ignored under the same rule.
- Extension: Signed = 1 replicates the lane MSB; otherwise zero-fill.
- Timeout:
  - Counter resets on entry to each request state and increments each cycle without ack.
  - When it reaches TIMEOUT_CYCLES: drop mem_req, fault = 1 -> DONE.
  - ReadData and memory are left unchanged. For a timed-out RMW, no write is issued.
- Latency with same-cycle ack (start at cycle T):
  - Load or word store: done at T+2.
  - Sub-word store: done at T+3.

Optional Feature:
- Macro: MAU_MISALIGN_TRAP_EN.
- Defined: a halfword with Adr[0] = 1, or a word with Adr[1:0] != 00, goes IDLE -> DONE with fault = 1 and no memory access.
- Undefined: low address bits are silently truncated and the access proceeds normally.

Decomposition:
- Shared package mem_pkg holds:
  - size-code constants SZ_WORD = 4'b1111, SZ_HALF = 4'b0011, SZ_BYTE = 4'b0001, SZ_BYTE0 = 4'b0000;
  - the FSM state enum;
  - the fault-cause constants.
- One natural sub-module, mem_lane_align: purely combinational. It does load extract/extend and store merge from (word, Adr[1:0], size, Signed, data).

Test Plan:
- Word load: Adr = 0x100, mem_rdata = 0xDEADBEEF, ack in the first request cycle -> ReadData = 0xDEADBEEF, done at T+2, fault = 0.
- Signed byte load: Adr = 0x102, mem_rdata = 0x12805634 -> ReadData = 0xFFFFFF80. With Signed = 0 -> 0x00000080.
- Halfword store RMW: Adr = 0x202, WriteData = 0x0000ABCD, read returns 0x11223344 -> write 0xABCD3344 to mem_adr = 0x200, done at T+3.
- Timeout: TIMEOUT_CYCLES = 4, mem_ack held 0 -> mem_req drops after 4 cycles, done with fault = 1, ReadData unchanged.
- start pulses while busy with ack delayed 3 cycles -> only the first command executes and exactly one done pulse is seen.
- Misaligned word load at Adr = 0x101:
  - with MAU_MISALIGN_TRAP_EN -> fault = 1, no mem_req;
  - without -> read issued at mem_adr = 0x100.
